// File: rtl/ibex_avalon_data_bridge.sv
// ibex_avalon_data_bridge
//   Bridges the Ibex data-bus port (bus_data_*) onto an Avalon-MM master interface.
//   Requests are forwarded combinationally. Up to MAX_OUTSTANDING transactions are tracked
//   in issue order. Writes retire locally, as soon as they reach the head, because Avalon
//   slaves here carry no write response. A read whose data never arrives is retired with
//   SLVERR after TIMEOUT_CYCLES, and its late data beat is later discarded.
// Ports
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   bus_read/write/addr/be/wdata         upstream request, held until accepted (~bus_busy)
//   bus_busy                             request not accepted this cycle (combinational)
//   bus_rvalid/rdata/resp, bus_wrespvalid registered in-order responses
//   avm_*                                Avalon-MM master side
//   outstanding_o                        in-flight transaction count
//   timeout_o                            pulse alongside a timeout-retired read response
module ibex_avalon_data_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_addr,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_wdata,
    output logic        bus_busy,
    output logic        bus_rvalid,
    output logic [31:0] bus_rdata,
    output logic [1:0]  bus_resp,
    output logic        bus_wrespvalid,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic [1:0]  avm_response,
    output logic [4:0]  outstanding_o,
    output logic        timeout_o
);

    localparam int unsigned AW       = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned DW       = 34;
    localparam int unsigned TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    // Order FIFO: one bit per transaction, 1 = write
    logic [MAX_OUTSTANDING-1:0] ord_mem_q, ord_mem_d;
    logic [AW-1:0]              ord_wp_q, ord_wp_d, ord_rp_q, ord_rp_d;
    logic [CW-1:0]              ord_cnt_q, ord_cnt_d;

    // Read-data FIFO: {response, readdata}
    logic [DW-1:0]              rd_mem_q [MAX_OUTSTANDING];
    logic [AW-1:0]              rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
    logic [CW-1:0]              rd_cnt_q, rd_cnt_d;

    logic [CW-1:0]              drop_q, drop_d;
    logic [TW-1:0]              tmo_q, tmo_d;

    logic                       rvalid_q, rvalid_d;
    logic                       wresp_q, wresp_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [1:0]                 resp_q, resp_d;
    logic                       timeout_q, timeout_d;

    logic full, accept, ord_empty, rd_empty;
    logic head_valid, head_is_wr, rdv_keep, rd_avail;
    logic retire_wr, retire_rd, tmo_fire, retire;
    logic ord_push, ord_pop, rd_push, rd_pop, drop_dec;
    logic [DW-1:0] rd_head;

    // Request path; everything forced low while reset is asserted
    always_comb begin
        full           = (ord_cnt_q == CW'(MAX_OUTSTANDING));
        avm_read       = rst_ni & bus_read & ~full;
        avm_write      = rst_ni & bus_write & ~full;
        bus_busy       = rst_ni & (full | avm_waitrequest);
        avm_address    = rst_ni ? bus_addr  : 32'h0;
        avm_byteenable = rst_ni ? bus_be    : 4'h0;
        avm_writedata  = rst_ni ? bus_wdata : 32'h0;
        accept         = (avm_read | avm_write) & ~avm_waitrequest;
    end

    // Head selection, retire decision and FIFO/counter next state
    always_comb begin
        ord_empty  = (ord_cnt_q == '0);
        rd_empty   = (rd_cnt_q == '0);
        head_valid = ~ord_empty | accept;
        // An accept into an empty tracker is its own head this cycle
        head_is_wr = ord_empty ? avm_write : ord_mem_q[ord_rp_q];
        rdv_keep   = avm_readdatavalid & (drop_q == '0);
        rd_avail   = ~rd_empty | rdv_keep;
        rd_head    = rd_empty ? {avm_response, avm_readdata} : rd_mem_q[rd_rp_q];

        retire_wr  = head_valid & head_is_wr;
        retire_rd  = head_valid & ~head_is_wr & rd_avail;
        tmo_fire   = (TIMEOUT_CYCLES != 0) & ~ord_empty & ~head_is_wr & ~rd_avail
                     & (tmo_q == TW'(TMO_LAST));
        retire     = retire_wr | retire_rd | tmo_fire;

        ord_push   = accept & ~(ord_empty & retire);
        ord_pop    = retire & ~ord_empty;
        rd_pop     = retire_rd & ~rd_empty;
        rd_push    = rdv_keep & ~(retire_rd & rd_empty);

        ord_mem_d  = ord_mem_q;
        ord_wp_d   = ord_wp_q;
        ord_rp_d   = ord_rp_q;
        if (ord_push) begin
            ord_mem_d[ord_wp_q] = avm_write;
            ord_wp_d            = ord_wp_q + AW'(1);
        end
        if (ord_pop) begin
            ord_rp_d = ord_rp_q + AW'(1);
        end
        ord_cnt_d  = ord_cnt_q + CW'(ord_push) - CW'(ord_pop);

        rd_wp_d    = rd_push ? rd_wp_q + AW'(1) : rd_wp_q;
        rd_rp_d    = rd_pop  ? rd_rp_q + AW'(1) : rd_rp_q;
        rd_cnt_d   = rd_cnt_q + CW'(rd_push) - CW'(rd_pop);

        // Beats owed to timed-out reads arrive first (Avalon returns reads in order)
        drop_dec   = avm_readdatavalid & (drop_q != '0);
        drop_d     = drop_q - CW'(drop_dec);
        if (tmo_fire && (drop_d != CW'(MAX_OUTSTANDING))) begin
            drop_d = drop_d + CW'(1);
        end

        tmo_d = tmo_q;
        if (ord_empty || retire || (TIMEOUT_CYCLES == 0)) begin
            tmo_d = '0;
        end else if (!head_is_wr && !rd_avail) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Response register next state; data/resp hold between responses
    always_comb begin
        rvalid_d  = retire_rd | tmo_fire;
        wresp_d   = retire_wr;
        timeout_d = tmo_fire;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        if (retire_rd) begin
            rdata_d = rd_head[31:0];
            resp_d  = rd_head[33:32];
        end else if (tmo_fire) begin
            rdata_d = 32'h0;
            resp_d  = 2'b10;
        end else if (retire_wr) begin
            resp_d  = 2'b00;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ord_mem_q <= '0;
            ord_wp_q  <= '0;
            ord_rp_q  <= '0;
            ord_cnt_q <= '0;
            rd_wp_q   <= '0;
            rd_rp_q   <= '0;
            rd_cnt_q  <= '0;
            drop_q    <= '0;
            tmo_q     <= '0;
            rvalid_q  <= 1'b0;
            wresp_q   <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                rd_mem_q[i] <= '0;
            end
        end else begin
            ord_mem_q <= ord_mem_d;
            ord_wp_q  <= ord_wp_d;
            ord_rp_q  <= ord_rp_d;
            ord_cnt_q <= ord_cnt_d;
            rd_wp_q   <= rd_wp_d;
            rd_rp_q   <= rd_rp_d;
            rd_cnt_q  <= rd_cnt_d;
            drop_q    <= drop_d;
            tmo_q     <= tmo_d;
            rvalid_q  <= rvalid_d;
            wresp_q   <= wresp_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            if (rd_push) begin
                rd_mem_q[rd_wp_q] <= {avm_response, avm_readdata};
            end
        end
    end

    assign bus_rvalid     = rvalid_q;
    assign bus_wrespvalid = wresp_q;
    assign bus_rdata      = rdata_q;
    assign bus_resp       = resp_q;
    assign timeout_o      = timeout_q;
    assign outstanding_o  = 5'(ord_cnt_q);

endmodule

// File: tb/tb_ibex_avalon_data_bridge.sv
// Testbench for ibex_avalon_data_bridge: directed requests and read beats, expected
// responses queued at issue time and checked in order by an independent monitor.
module tb_ibex_avalon_data_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        bus_read = 1'b0;
    logic        bus_write = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [3:0]  bus_be = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_busy;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_resp;
    logic        bus_wrespvalid;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic [1:0]  avm_response = '0;
    logic [4:0]  outstanding_o;
    logic        timeout_o;

    ibex_avalon_data_bridge #(
        .MAX_OUTSTANDING(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .bus_read          (bus_read),
        .bus_write         (bus_write),
        .bus_addr          (bus_addr),
        .bus_be            (bus_be),
        .bus_wdata         (bus_wdata),
        .bus_busy          (bus_busy),
        .bus_rvalid        (bus_rvalid),
        .bus_rdata         (bus_rdata),
        .bus_resp          (bus_resp),
        .bus_wrespvalid    (bus_wrespvalid),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_response      (avm_response),
        .outstanding_o     (outstanding_o),
        .timeout_o         (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every response pops the oldest expectation
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus_rvalid || bus_wrespvalid) begin
                chk("resp_exclusive", 64'(bus_rvalid & bus_wrespvalid), 64'(0));
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_resp: got rvalid=%0b wresp=%0b expected none (t=%0t)",
                             bus_rvalid, bus_wrespvalid, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_kind", 64'(bus_wrespvalid), 64'(mon_e.is_wr));
                    chk("resp_code", 64'(bus_resp), 64'(mon_e.resp));
                    if (!mon_e.is_wr) begin
                        chk("rdata", 64'(bus_rdata), 64'(mon_e.data));
                        chk("timeout_pulse", 64'(timeout_o), 64'(mon_e.tmo));
                    end
                end
            end else if (timeout_o) begin
                chk("stray_timeout", 64'(timeout_o), 64'(0));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push_rd(input logic [31:0] d, input logic [1:0] r, input bit t);
        exp_t e;
        e.is_wr = 1'b0; e.data = d; e.resp = r; e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic push_wr();
        exp_t e;
        e.is_wr = 1'b1; e.data = '0; e.resp = 2'b00; e.tmo = 1'b0;
        sb.push_back(e);
    endtask

    // Issue one request, holding it until accepted; first 'stall' cycles see waitrequest
    task automatic req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int stall);
        bit acc;
        acc       = 1'b0;
        bus_read  = !wr;
        bus_write = wr;
        bus_addr  = addr;
        bus_be    = 4'hf;
        bus_wdata = wdata;
        for (int i = 0; i < 50; i++) begin
            avm_waitrequest = (i < stall);
            @(negedge clk_i);
            if (i < stall) begin
                chk("busy_stall", 64'(bus_busy), 64'(1));
            end
            acc = !bus_busy;
            if (acc) begin
                chk("avm_addr", 64'(avm_address), 64'(addr));
                chk("avm_cmd", 64'({avm_read, avm_write}), 64'({!wr, wr}));
            end
            @(posedge clk_i);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_accept: got busy for 50 cycles expected acceptance");
        end
        bus_read        = 1'b0;
        bus_write       = 1'b0;
        avm_waitrequest = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] r);
        avm_readdatavalid = 1'b1;
        avm_readdata      = d;
        avm_response      = r;
        @(posedge clk_i);
        #1;
        avm_readdatavalid = 1'b0;
        avm_response      = 2'b00;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 64'({bus_busy, bus_rvalid, bus_resp, bus_wrespvalid, avm_read,
                                 avm_write, avm_byteenable, outstanding_o, timeout_o}), 64'(0));
        chk({tag, "_data"}, {bus_rdata, avm_address}, 64'(0));
        chk({tag, "_wdata"}, 64'(avm_writedata), 64'(0));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) cyc(1);
        chk(tag, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        // Reset state
        cyc(2);
        @(negedge clk_i);
        chk_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cyc(1);

        // 1: single read with waitrequest stall, data 3 cycles after accept
        push_rd(32'h1234_5678, 2'b00, 1'b0);
        req(1'b0, 32'h0000_0100, 32'h0, 2);
        cyc(2);
        beat(32'h1234_5678, 2'b00);
        chk("t1_rd_latency", 64'(bus_rvalid), 64'(1));
        cyc(1);

        // Lone write is acknowledged the cycle after accept
        push_wr();
        req(1'b1, 32'h0000_0200, 32'hAAAA_5555, 0);
        chk("wr_latency", 64'(bus_wrespvalid), 64'(1));
        cyc(1);

        // 2: read then write back-to-back, read data 5 cycles late
        push_rd(32'h0000_BEEF, 2'b00, 1'b0);
        req(1'b0, 32'h0000_0300, 32'h0, 0);
        push_wr();
        req(1'b1, 32'h0000_0304, 32'h1111_2222, 0);
        chk("t2_outstanding", 64'(outstanding_o), 64'(2));
        cyc(3);
        beat(32'h0000_BEEF, 2'b00);
        chk("t2_rvalid_first", 64'({bus_rvalid, bus_wrespvalid}), 64'(2'b10));
        cyc(1);
        chk("t2_wresp_next", 64'({bus_rvalid, bus_wrespvalid}), 64'(2'b01));
        cyc(1);

        // 3: fill to four outstanding reads, fifth is held off
        for (int i = 0; i < 4; i++) begin
            push_rd(32'h3000_0000 + 32'(i), 2'b00, 1'b0);
            req(1'b0, 32'h0000_0400 + 32'(4 * i), 32'h0, 0);
        end
        bus_read = 1'b1;
        bus_addr = 32'h0000_0410;
        @(negedge clk_i);
        chk("t3_busy_full", 64'(bus_busy), 64'(1));
        chk("t3_avm_read_low", 64'(avm_read), 64'(0));
        chk("t3_outstanding_4", 64'(outstanding_o), 64'(4));
        @(posedge clk_i);
        #1;
        bus_read = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'h3000_0000 + 32'(i), 2'b00);
        cyc(1);
        chk("t3_outstanding_0", 64'(outstanding_o), 64'(0));
        drain("t3_drain");

        // 4: unanswered read times out; its late beat is dropped
        push_rd(32'h0, 2'b10, 1'b1);
        req(1'b0, 32'h0000_0500, 32'h0, 0);
        drain("t4_timeout_seen");
        push_rd(32'hCAFE_F00D, 2'b00, 1'b0);
        req(1'b0, 32'h0000_0504, 32'h0, 0);
        cyc(1);
        beat(32'hDEAD_0000, 2'b00);
        beat(32'hCAFE_F00D, 2'b00);
        cyc(2);
        drain("t4_drain");

        // 5: slave error passes through without a timeout
        push_rd(32'hDEAD_BEEF, 2'b10, 1'b0);
        req(1'b0, 32'h0000_0600, 32'h0, 0);
        cyc(1);
        beat(32'hDEAD_BEEF, 2'b10);
        cyc(2);
        drain("t5_drain");

        // 6: reset with three reads in flight
        for (int i = 0; i < 3; i++) req(1'b0, 32'h0000_0700 + 32'(4 * i), 32'h0, 0);
        cyc(1);
        chk("t6_outstanding_3", 64'(outstanding_o), 64'(3));
        bus_read        = 1'b1;
        bus_wdata       = 32'h5A5A_5A5A;
        avm_waitrequest = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("t6_reset");
        sb.delete();
        cyc(2);
        bus_read        = 1'b0;
        avm_waitrequest = 1'b0;
        rst_ni          = 1'b1;
        cyc(1);
        push_rd(32'h0BAD_F00D, 2'b00, 1'b0);
        req(1'b0, 32'h0000_0800, 32'h0, 0);
        cyc(1);
        beat(32'h0BAD_F00D, 2'b00);
        cyc(2);
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
